lcd_ahb_mem_slave: RTL and testbench
====================================

Name: lcd_ahb_mem_slave

Overview:
AHB-Lite style memory responder that serves the LCD controller's burst fetches. It also acts as the frame-buffer model and test target for the bus master.
- Accepts single and INCR bursts (reads and writes) from the bus master.
- Inserts programmable wait states.
- Returns the two-cycle ERROR response for illegal accesses.

Parameters:
DEPTH, 1024, number of 32-bit words in the array (power of two)
BASE, 32'h0000_0000, byte address of word 0; accesses outside BASE..BASE+4*DEPTH-1 are errors
NSEQ_WAIT, 1, wait states inserted for a NONSEQ beat (0..7)
SEQ_WAIT, 0, wait states inserted for a SEQ beat (0..7)

Ports:
HCLK  in  1  bus clock, all state on rising edge
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select, address phase
HADDR  in  32  byte address, address phase
HTRANS  in  2  0=IDLE 1=BUSY 2=NONSEQ 3=SEQ
HWRITE  in  1  1=write
HSIZE  in  3  transfer size
HBURST  in  3  burst type, ignored apart from being legal
HWDATA  in  32  write data, data phase
HREADY  in  1  bus-level ready; an address phase is valid only when high
HRDATA  out  32  read data, valid when HREADYOUT=1 in a read data phase
HREADYOUT  out  1  0 = extend current data phase
HRESP  out  2  0=OKAY 1=ERROR

Behaviour:
- Reset (async assert, sync-free release): HREADYOUT=1, HRESP=OKAY, HRDATA=0, state D_IDLE, wait counter 0, any pending write discarded. Array contents are not reset.
- Accept condition: HSEL && HREADY && HTRANS[1]. Accepted beats have HADDR/HWRITE/HSIZE/HTRANS registered for the data phase.
- IDLE or BUSY, or HSEL low: no data phase; next cycle is D_IDLE with zero-wait OKAY.
- Error check at accept: an accept is an error if any of these hold:
  - address out of range;
  - HADDR[1:0]!=0;
  - HSIZE!=2, unless the optional feature is enabled.
- FSM states: D_IDLE, D_WAIT, D_LAST, D_ERR1, D_ERR2.
- D_IDLE: HREADYOUT=1. On accept:
  - error → D_ERR1;
  - else wait count w = NSEQ_WAIT or SEQ_WAIT by HTRANS; w>0 → D_WAIT with counter=w-1; w=0 → D_LAST.
- D_WAIT: HREADYOUT=0, HRESP=OKAY. Counter decrements each cycle; at 0 → D_LAST.
- D_LAST: HREADYOUT=1, HRESP=OKAY.
  - Read: HRDATA=mem[index].
  - Write: HWDATA is committed to mem[index] at the end of this cycle.
  - A new accept in this same cycle is evaluated exactly as in D_IDLE (back-to-back pipelining); with no accept → D_IDLE.
- D_ERR1: HREADYOUT=0, HRESP=ERROR → D_ERR2.
- D_ERR2: HREADYOUT=1, HRESP=ERROR. An accept here is evaluated as in D_IDLE. No array write on an error beat.
- Array indexing: index = (HADDR-BASE)>>2, width clog2(DEPTH). A burst crossing the array end errors on the first out-of-range beat only; earlier beats complete OKAY.
- Read-after-write to the same word with zero waits returns the new data, because the commit precedes the read's data phase.
- HRDATA holds its last value outside read D_LAST cycles.
- BUSY inside a burst is an accept-free cycle and does not reset burst state.

Optional Feature:
LCD_SLV_BYTE_LANE_EN
- Defined: HSIZE 0 and 1 are legal.
  - Byte: any HADDR[1:0]. Halfword: HADDR[0]=0; otherwise ERROR.
  - Writes update only the addressed lanes (little-endian). Reads return the full word.
- Undefined: any HSIZE!=2 produces ERROR, and writes are always whole-word.

Decomposition:
- Package lcd_ahb_pkg:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ);
  - hresp_t (OKAY, ERROR);
  - HSIZE_BYTE/HALF/WORD constants;
  - dstate_t FSM enum.
- The master side imports the same package.
- One sub-module, lcd_slv_mem: DEPTH x 32 array with 4-bit byte write enable, combinational read, synchronous write.

Test Plan:
- NSEQ_WAIT=1, SEQ_WAIT=0. Write NONSEQ 0x10 = 0xDEAD_BEEF, then read 0x10 → exactly 1 wait cycle per NONSEQ beat, HRDATA=0xDEAD_BEEF, HRESP=OKAY.
- 8-beat INCR read from 0x40 (NONSEQ then 7 SEQ) with mem[16..23]=16..23 → 1 wait on beat 0, then 7 consecutive HREADYOUT=1 cycles returning 16..23 in order.
- Read at BASE+4*DEPTH → HREADYOUT 0 then 1, with HRESP=ERROR for both cycles; a following valid read of 0x0 completes OKAY.
- HSIZE=0 write 0xAA to 0x21 over mem[8]=0x1122_3344 → with the macro: mem[8]=0x1122_AA44, OKAY. Without the macro: ERROR, mem[8] unchanged.
- HRESETn asserted during a D_WAIT write to 0x8 → HREADYOUT=1 and HRESP=OKAY immediately, mem[2] unchanged after release.
- Write 0x5 to 0x30 immediately followed by a read of 0x30 with zero waits → read returns 0x5; a BUSY inserted mid-burst delays that beat with no extra wait.

Source files
------------

// File: rtl/lcd_ahb_pkg.sv
// Shared AHB-Lite definitions for the LCD bus master and the memory responder.
package lcd_ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [1:0] {
    OKAY  = 2'd0,
    ERROR = 2'd1
  } hresp_t;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Data-phase states of the memory responder
  typedef enum logic [2:0] {
    D_IDLE = 3'd0,
    D_WAIT = 3'd1,
    D_LAST = 3'd2,
    D_ERR1 = 3'd3,
    D_ERR2 = 3'd4
  } dstate_t;

  // Little-endian byte-lane mask for a transfer of the given size and offset
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] m;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << lo;
      HSIZE_HALF: m = 4'b0011 << lo;
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lcd_slv_mem.sv
// DEPTH x 32 word array: combinational read, synchronous byte-enabled write.
module lcd_slv_mem #(
  parameter int DEPTH = 1024
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [3:0]                 be_i,
  input  logic [$clog2(DEPTH)-1:0]   addr_i,
  input  logic [31:0]                wdata_i,
  output logic [31:0]                rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Commit the enabled byte lanes at the clock edge; contents are never reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/lcd_ahb_mem_slave.sv
// AHB-Lite memory responder with programmable wait states and ERROR response.
// Optional build macro LCD_SLV_BYTE_LANE_EN enables byte/halfword transfers.
module lcd_ahb_mem_slave #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE      = 32'h0000_0000,
  parameter int          NSEQ_WAIT = 1,
  parameter int          SEQ_WAIT  = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP
);
  import lcd_ahb_pkg::*;

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [32:0] SPAN   = 33'(4 * DEPTH);
  localparam logic [2:0]  NSEQ_W = 3'(NSEQ_WAIT);
  localparam logic [2:0]  SEQ_W  = 3'(SEQ_WAIT);

  dstate_t        state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [AW-1:0]  idx_q;
  logic           write_q;
  logic [3:0]     be_q;
  logic [31:0]    hrdata_q, hrdata_d;
  logic           capture;
  logic           mem_we;
  logic [31:0]    mem_rdata;
  hresp_t         hresp_c;

  // Address-phase decode; a 33-bit difference catches addresses below BASE
  logic           accept;
  logic [32:0]    diff;
  logic           in_range;
  logic           size_err;
  logic           acc_err;
  logic [3:0]     be_acc;
  logic [2:0]     wait_sel;
  logic           unused_ok;

  assign accept   = HSEL & HREADY & HTRANS[1];
  assign diff     = {1'b0, HADDR} - {1'b0, BASE};
  assign in_range = ~diff[32] && (diff < SPAN);
  assign wait_sel = (htrans_t'(HTRANS) == SEQ) ? SEQ_W : NSEQ_W;
  assign unused_ok = ^HBURST;

`ifdef LCD_SLV_BYTE_LANE_EN
  // Sub-word transfers are legal when naturally aligned to their size
  always_comb begin
    case (HSIZE)
      HSIZE_BYTE: size_err = 1'b0;
      HSIZE_HALF: size_err = HADDR[0];
      HSIZE_WORD: size_err = |HADDR[1:0];
      default:    size_err = 1'b1;
    endcase
  end
  assign be_acc = lane_mask(HSIZE, HADDR[1:0]);
`else
  assign size_err = (HSIZE != HSIZE_WORD) || (HADDR[1:0] != 2'b00);
  assign be_acc   = 4'hF;
`endif

  assign acc_err = ~in_range | size_err;

  // State register and wait counter
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= D_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: IDLE, LAST and ERR2 all accept a new beat the same way
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      D_WAIT: begin
        if (cnt_q == 3'd0) state_d = D_LAST;
        else               cnt_d   = cnt_q - 3'd1;
      end
      D_ERR1: state_d = D_ERR2;
      default: begin
        state_d = D_IDLE;
        if (accept) begin
          capture = 1'b1;
          if (acc_err) begin
            state_d = D_ERR1;
          end else if (wait_sel != 3'd0) begin
            state_d = D_WAIT;
            cnt_d   = wait_sel - 3'd1;
          end else begin
            state_d = D_LAST;
          end
        end
      end
    endcase
  end

  // Outputs: ready/response per state, write commit and read data in D_LAST
  always_comb begin
    HREADYOUT = 1'b1;
    hresp_c   = OKAY;
    mem_we    = 1'b0;
    hrdata_d  = hrdata_q;
    case (state_q)
      D_WAIT: HREADYOUT = 1'b0;
      D_LAST: begin
        if (write_q) mem_we   = 1'b1;
        else         hrdata_d = mem_rdata;
      end
      D_ERR1: begin
        HREADYOUT = 1'b0;
        hresp_c   = ERROR;
      end
      D_ERR2: hresp_c = ERROR;
      default: ;
    endcase
  end

  assign HRESP  = hresp_c;
  assign HRDATA = hrdata_d;

  // Data-phase copy of the accepted address phase, plus held read data
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      idx_q    <= '0;
      write_q  <= 1'b0;
      be_q     <= 4'h0;
      hrdata_q <= 32'h0;
    end else begin
      hrdata_q <= hrdata_d;
      if (capture) begin
        idx_q   <= diff[AW+1:2];
        write_q <= HWRITE;
        be_q    <= be_acc;
      end
    end
  end

  lcd_slv_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_i   (HCLK),
    .we_i    (mem_we),
    .be_i    (be_q),
    .addr_i  (idx_q),
    .wdata_i (HWDATA),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_lcd_ahb_mem_slave.sv
// Randomised bench for lcd_ahb_mem_slave against a word-array reference model.
module tb_lcd_ahb_mem_slave;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          NW    = 1;
  localparam int          SW    = 0;

  logic        HCLK, HRESETn, HSEL, HWRITE, HREADY, HREADYOUT;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, HRESP;
  logic [2:0]  HSIZE, HBURST;

  assign HREADY = HREADYOUT;

  lcd_ahb_mem_slave #(.DEPTH(DEPTH), .BASE(BASE), .NSEQ_WAIT(NW), .SEQ_WAIT(SW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } beat_t;

  beat_t       q[$];
  logic [31:0] model_mem [DEPTH];
  int          total = 0;
  int          bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                               input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] wdata);
    beat_t b;
    b.sel = sel; b.trans = trans; b.wr = wr; b.addr = addr; b.size = size; b.wdata = wdata;
    return b;
  endfunction

  // Legality straight from the address map and size rules
  function automatic bit ref_err(input logic [31:0] a, input logic [2:0] s);
    longint d;
    bit     e;
    d = longint'(a) - longint'(BASE);
    e = (d < 0) || (d >= 4 * DEPTH);
`ifdef LCD_SLV_BYTE_LANE_EN
    if (s == 3'd1 && a[0]) e = 1;
    if (s == 3'd2 && a[1:0] != 2'b00) e = 1;
    if (s > 3'd2) e = 1;
`else
    if (s != 3'd2 || a[1:0] != 2'b00) e = 1;
`endif
    return e;
  endfunction

  function automatic int ref_idx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
    int idx;
    idx = ref_idx(a);
`ifdef LCD_SLV_BYTE_LANE_EN
    for (int k = 0; k < 4; k++) begin
      if (k >= int'(a[1:0]) && k < int'(a[1:0]) + (1 << s))
        model_mem[idx][8*k +: 8] = wd[8*k +: 8];
    end
`else
    s = s;
    model_mem[idx] = wd;
`endif
  endtask

  task automatic drive_ap(input beat_t b);
    HSEL = b.sel; HTRANS = b.trans; HWRITE = b.wr;
    HADDR = b.addr; HSIZE = b.size; HBURST = 3'd1;
  endtask

  // Called on the cycle a data phase completes (HREADYOUT high)
  task automatic complete_beat(input beat_t b, input int waits);
    bit e;
    int expw;
    e    = ref_err(b.addr, b.size);
    expw = e ? 1 : ((b.trans == 2'd3) ? SW : NW);
    $display("beat %s trans=%0d addr=%h size=%0d waits=%0d resp=%0d rdata=%h",
             b.wr ? "WR" : "RD", b.trans, b.addr, b.size, waits, HRESP, HRDATA);
    check_val("resp", {30'b0, HRESP}, e ? 32'd1 : 32'd0);
    check_val("waits", waits, expw);
    if (!e) begin
      if (b.wr) ref_write(b.addr, b.size, b.wdata);
      else      check_val("rdata", HRDATA, model_mem[ref_idx(b.addr)]);
    end
  endtask

  // Pipelined master: entered and left just after a rising edge
  task automatic run_queue(input int budget);
    beat_t ap, dp;
    bit    ap_xfer, dp_valid, done;
    int    waits, cycles;
    dp_valid = 0; waits = 0; cycles = 0;
    dp = mk(0, 2'd0, 0, 32'h0, 3'd2, 32'h0);
    ap = (q.size() > 0) ? q.pop_front() : dp;
    drive_ap(ap);
    ap_xfer = ap.sel && ap.trans[1];
    while ((q.size() > 0 || ap_xfer || dp_valid) && cycles < budget) begin
      @(negedge HCLK);
      done = HREADYOUT;
      if (dp_valid) begin
        if (!done) begin
          waits++;
          check_val("wresp", {30'b0, HRESP}, ref_err(dp.addr, dp.size) ? 32'd1 : 32'd0);
        end else begin
          complete_beat(dp, waits);
        end
      end
      @(posedge HCLK); #1;
      cycles++;
      if (done) begin
        dp_valid = ap_xfer; dp = ap; waits = 0;
        HWDATA = ap.wdata;
        ap = (q.size() > 0) ? q.pop_front() : mk(0, 2'd0, 0, 32'h0, 3'd2, 32'h0);
        drive_ap(ap);
        ap_xfer = ap.sel && ap.trans[1];
      end
    end
    if (cycles >= budget) check_val("timeout", 32'd1, 32'd0);
  endtask

  function automatic beat_t rand_beat();
    int          r, w;
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic [31:0] a;
    r  = $urandom_range(0, 99);
    tr = (r < 8) ? 2'd0 : (r < 16) ? 2'd1 : (r < 50) ? 2'd2 : 2'd3;
    r  = $urandom_range(0, 99);
    w  = (r < 70) ? $urandom_range(0, 63) : (r < 85) ? $urandom_range(1016, 1023)
                                                       : $urandom_range(1024, 1031);
    a  = BASE + 32'(w * 4);
    if ($urandom_range(0, 99) < 15) a[1:0] = 2'($urandom_range(0, 3));
    sz = ($urandom_range(0, 99) < 80) ? 3'd2 : 3'($urandom_range(0, 3));
    return mk($urandom_range(0, 19) != 0, tr, 1'($urandom_range(0, 1)), a, sz, $urandom);
  endfunction

  initial begin
    HRESETn = 1'b0; HWDATA = 32'h0;
    drive_ap(mk(0, 2'd0, 0, 32'h0, 3'd2, 32'h0));
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check_val("rst_ready", {31'b0, HREADYOUT}, 32'd1);
    check_val("rst_resp", {30'b0, HRESP}, 32'd0);
    check_val("rst_hrdata", HRDATA, 32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Known contents for the windows random traffic touches
    for (int w = 0; w < 64; w++)
      q.push_back(mk(1, (w % 8 == 0) ? 2'd2 : 2'd3, 1, BASE + 32'(w * 4), 3'd2,
                     (w >= 16 && w < 24) ? 32'(w) : $urandom));
    for (int w = 1016; w < 1024; w++)
      q.push_back(mk(1, (w == 1016) ? 2'd2 : 2'd3, 1, BASE + 32'(w * 4), 3'd2, $urandom));
    run_queue(2000);

    // Single NONSEQ write then read
    q.push_back(mk(1, 2'd2, 1, 32'h10, 3'd2, 32'hDEAD_BEEF));
    q.push_back(mk(1, 2'd2, 0, 32'h10, 3'd2, 32'h0));
    run_queue(100);
    check_val("rd_deadbeef", HRDATA, 32'hDEAD_BEEF);

    // 8-beat INCR read
    for (int i = 0; i < 8; i++)
      q.push_back(mk(1, (i == 0) ? 2'd2 : 2'd3, 0, 32'h40 + 32'(4 * i), 3'd2, 32'h0));
    run_queue(100);
    check_val("burst_last", HRDATA, 32'd23);

    // Out-of-range then a valid read
    q.push_back(mk(1, 2'd2, 0, BASE + 32'(4 * DEPTH), 3'd2, 32'h0));
    q.push_back(mk(1, 2'd2, 0, 32'h0, 3'd2, 32'h0));
    run_queue(100);

    // Byte write into lane 1
    q.push_back(mk(1, 2'd2, 1, 32'h20, 3'd2, 32'h1122_3344));
    q.push_back(mk(1, 2'd2, 1, 32'h21, 3'd0, 32'hAAAA_AAAA));
    q.push_back(mk(1, 2'd2, 0, 32'h20, 3'd2, 32'h0));
    run_queue(100);
`ifdef LCD_SLV_BYTE_LANE_EN
    check_val("byte_lane", HRDATA, 32'h1122_AA44);
`else
    check_val("byte_lane", HRDATA, 32'h1122_3344);
`endif

    // Zero-wait read-after-write inside a burst
    q.push_back(mk(1, 2'd2, 1, 32'h2C, 3'd2, 32'h0000_0777));
    q.push_back(mk(1, 2'd3, 1, 32'h30, 3'd2, 32'h0000_0005));
    q.push_back(mk(1, 2'd3, 0, 32'h30, 3'd2, 32'h0));
    run_queue(100);
    check_val("raw", HRDATA, 32'h5);

    // BUSY in the middle of a burst
    q.push_back(mk(1, 2'd2, 0, 32'h40, 3'd2, 32'h0));
    q.push_back(mk(1, 2'd1, 0, 32'h44, 3'd2, 32'h0));
    q.push_back(mk(1, 2'd3, 0, 32'h44, 3'd2, 32'h0));
    q.push_back(mk(1, 2'd3, 0, 32'h48, 3'd2, 32'h0));
    run_queue(100);
    check_val("busy_burst", HRDATA, 32'd18);

    // Random traffic
    for (int i = 0; i < 300; i++) q.push_back(rand_beat());
    run_queue(5000);

    // Reset while a write sits in its wait state
    drive_ap(mk(1, 2'd2, 1, 32'h8, 3'd2, 32'h0));
    @(posedge HCLK); #1;
    drive_ap(mk(0, 2'd0, 0, 32'h0, 3'd2, 32'h0));
    HWDATA = 32'hBAD0_BAD0;
    #1;
    check_val("rst_inwait", {31'b0, HREADYOUT}, 32'd0);
    HRESETn = 1'b0;
    #1;
    check_val("rst_async_ready", {31'b0, HREADYOUT}, 32'd1);
    check_val("rst_async_resp", {30'b0, HRESP}, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    q.push_back(mk(1, 2'd2, 0, 32'h8, 3'd2, 32'h0));
    run_queue(100);

    // Read data holds through idle cycles
    repeat (3) @(posedge HCLK);
    #1;
    check_val("hold", HRDATA, model_mem[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
